// File: rtl/pwm_breathe_multi.sv
// N-channel PWM LED driver with per-channel triangle breathing.
// All timing is derived from clock-enable ticks in the clk domain; duty values
// are latched only at the PWM period boundary so outputs never glitch mid-period.
module pwm_breathe_multi #(
    parameter int CHANNELS   = 6,
    parameter int PWM_W      = 8,
    parameter int PRESCALE   = 105,
    parameter int STEP_DIV   = 52734,
    parameter int STEP       = 1,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [PWM_W-1:0]    static_duty,
    output logic [CHANNELS-1:0] led,
    output logic                period_tick
);

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_STATIC  = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SD_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [SD_W-1:0]  SD_LAST = SD_W'(STEP_DIV - 1);
    localparam logic [PWM_W-1:0] PWM_MAX = {PWM_W{1'b1}};
    localparam logic [PWM_W:0]   STEP_V  = (PWM_W + 1)'(STEP);

    logic [PS_W-1:0]  presc_q, presc_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [SD_W-1:0]  step_cnt_q, step_cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             period_tick_q;

    logic tick;
    logic boundary;
    logic breathing;
    logic step;

    // Shared strobes: PWM tick, period boundary and breathing phase step
    always_comb begin
        tick      = en && (presc_q == PS_LAST);
        boundary  = tick && (pwm_cnt_q == PWM_MAX);
        breathing = en && (mode_q == MODE_BREATHE);
        step      = breathing && (step_cnt_q == SD_LAST);
    end

    // Next state of the shared counters; en=0 parks everything at zero
    always_comb begin
        presc_d    = presc_q;
        pwm_cnt_d  = pwm_cnt_q;
        step_cnt_d = step_cnt_q;
        mode_d     = mode_q;
        if (!en) begin
            presc_d    = '0;
            pwm_cnt_d  = '0;
            step_cnt_d = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                pwm_cnt_d = pwm_cnt_q + 1'b1;
            end
            if (boundary) begin
                mode_d = mode;
            end
            if (breathing) begin
                step_cnt_d = step ? '0 : step_cnt_q + 1'b1;
            end
        end
    end

    // Shared counter and strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            pwm_cnt_q     <= '0;
            step_cnt_q    <= '0;
            mode_q        <= MODE_OFF;
            period_tick_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            pwm_cnt_q     <= pwm_cnt_d;
            step_cnt_q    <= step_cnt_d;
            mode_q        <= mode_d;
            period_tick_q <= boundary;
        end
    end

    assign period_tick = period_tick_q;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            // Phases start evenly spread over the full up/down cycle
            localparam logic [PWM_W:0] PH_INIT =
                (PWM_W + 1)'((gi * (1 << (PWM_W + 1))) / CHANNELS);

            logic [PWM_W:0]   ph_q;
            logic [PWM_W-1:0] duty_sh_q;
            logic [PWM_W-1:0] duty_next;
            logic             on;
            logic             led_q;

            // Duty this channel would adopt at the next boundary (MSB of phase = falling half)
            always_comb begin
                duty_next = '0;
                case (mode)
                    MODE_STATIC:  duty_next = static_duty;
                    MODE_BREATHE: duty_next = ph_q[PWM_W] ? ~ph_q[PWM_W-1:0] : ph_q[PWM_W-1:0];
                    default:      duty_next = '0;
                endcase
            end

            // Compare: MAX forces always-on so full brightness has no dark tick
            always_comb begin
                on = (duty_sh_q == PWM_MAX) || (pwm_cnt_q < duty_sh_q);
            end

            // Phase accumulator; holds whenever breathing is paused
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ph_q <= PH_INIT;
                end else if (step) begin
                    ph_q <= ph_q + STEP_V;
                end
            end

            // Shadow duty, updated only at the period boundary
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    duty_sh_q <= '0;
                end else if (!en) begin
                    duty_sh_q <= '0;
                end else if (boundary) begin
                    duty_sh_q <= duty_next;
                end
            end

            // Registered LED output with optional inversion
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    led_q <= ACTIVE_LOW;
                end else if (!en) begin
                    led_q <= ACTIVE_LOW;
                end else begin
                    led_q <= on ^ ACTIVE_LOW;
                end
            end

            assign led[gi] = led_q;
        end
    endgenerate

endmodule

// File: tb/tb_pwm_breathe_multi.sv
// Directed bench for pwm_breathe_multi (4 channels, 4-bit PWM, 32-clk period).
// Expected per-period high-clock counts are queued when stimulus is applied and
// popped when the measured period completes. A second instance with inverted
// outputs runs in lockstep and must always be the bitwise complement.
module tb_pwm_breathe_multi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] static_duty = 4'd0;
    logic [3:0] led, led_al;
    logic       ptick, ptick_al;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    pwm_breathe_multi #(.CHANNELS(4), .PWM_W(4), .PRESCALE(2), .STEP_DIV(8),
                        .STEP(1), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .static_duty(static_duty), .led(led), .period_tick(ptick));

    pwm_breathe_multi #(.CHANNELS(4), .PWM_W(4), .PRESCALE(2), .STEP_DIV(8),
                        .STEP(1), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .static_duty(static_duty), .led(led_al), .period_tick(ptick_al));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int tri_wave(input logic [4:0] ph);
        logic [3:0] v;
        v = ph[4] ? ~ph[3:0] : ph[3:0];
        return int'(v);
    endfunction

    function automatic int hi_clks(input int d);
        return (d == 15) ? 32 : 2 * d;
    endfunction

    task automatic push4(input int a, input int b, input int c, input int d);
        exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
    endtask

    // Wait (bounded) for period_tick; optionally require darkness and exact latency
    task automatic wait_ptick(input string tag, input bit chk_dark, input int exp_cyc);
        int  cyc = 0;
        int  hi  = 0;
        bit  seen = 1'b0;
        while (cyc < 200 && !seen) begin
            @(negedge clk);
            cyc++;
            hi += $countones(led);
            if (ptick === 1'b1) seen = 1'b1;
        end
        check({tag, "_ptick_seen"}, 32'(seen), 32'd1);
        if (exp_cyc > 0) check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        if (chk_dark) check({tag, "_dark"}, 32'(hi), 32'd0);
    endtask

    // Measure one full period that starts right after the current period_tick cycle
    task automatic measure(input string tag, input bit chg, input logic [1:0] nmode,
                           input logic [3:0] nduty);
        int hi[4];
        int pt = 0;
        int inv_bad = 0;
        int e;
        for (int c = 0; c < 4; c++) hi[c] = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) hi[c] += int'(led[c]);
            pt += int'(ptick);
            if (led_al !== ~led) inv_bad++;
            if (ptick_al !== ptick) inv_bad++;
            if (chg && i == 15) begin
                mode = nmode;
                static_duty = nduty;
            end
        end
        for (int c = 0; c < 4; c++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            check($sformatf("%s_ch%0d_hi", tag, c), 32'(hi[c]), 32'(e));
        end
        check({tag, "_ptick_count"}, 32'(pt), 32'd1);
        check({tag, "_ptick_at_end"}, 32'(ptick), 32'd1);
        check({tag, "_inverted"}, 32'(inv_bad), 32'd0);
    endtask

    // Pulse reset mid-period and confirm outputs drop before the next clock edge
    task automatic reset_pulse(input string tag, input int exp_pre);
        repeat (3) @(negedge clk);
        if (exp_pre >= 0) check({tag, "_pre_led"}, 32'(led), 32'(exp_pre));
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_async_led"}, 32'(led), 32'h0);
        check({tag, "_async_led_al"}, 32'(led_al), 32'hF);
        check({tag, "_async_ptick"}, 32'(ptick), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int off;
        // Reset state
        repeat (2) @(negedge clk);
        check("reset_led", 32'(led), 32'h0);
        check("reset_led_al", 32'(led_al), 32'hF);
        check("reset_ptick", 32'(ptick), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("en0_led", 32'(led), 32'h0);
        check("en0_ptick", 32'(ptick), 32'd0);

        // Static mode: duty sequence 5, 0, 15, 5 -> 9 (changed mid-period), 9
        @(posedge clk);
        #1 en = 1'b1; mode = 2'b01; static_duty = 4'd5;
        wait_ptick("static_first", 1'b1, 33);
        push4(10, 10, 10, 10); measure("static5",   1'b1, 2'b01, 4'd0);
        push4(0, 0, 0, 0);     measure("static0",   1'b1, 2'b01, 4'd15);
        push4(32, 32, 32, 32); measure("static15",  1'b1, 2'b01, 4'd5);
        push4(10, 10, 10, 10); measure("duty5to9",  1'b1, 2'b01, 4'd9);
        push4(18, 18, 18, 18); measure("static9",   1'b0, 2'b01, 4'd9);

        // Breathe from reset: phases 0,8,16,24; boundary k sees offset 4k-1 (k>=1)
        mode = 2'b10;
        reset_pulse("rst_static", 32'hF);
        for (int k = 0; k < 9; k++) begin
            off = (k == 0) ? 0 : 4 * k - 1;
            push4(hi_clks(tri_wave(5'(0 + off))),  hi_clks(tri_wave(5'(8 + off))),
                  hi_clks(tri_wave(5'(16 + off))), hi_clks(tri_wave(5'(24 + off))));
        end
        wait_ptick("breathe_first", 1'b1, 33);
        for (int k = 0; k < 9; k++) measure($sformatf("breathe_p%0d", k), 1'b0, 2'b10, 4'd0);

        // Reset mid-period in breathe: phases reload
        reset_pulse("rst_breathe", -1);
        push4(0, 16, 32, 14);
        wait_ptick("breathe2_first", 1'b1, 33);
        measure("breathe2_p0", 1'b0, 2'b10, 4'd0);

        // Disable, then re-enable in static mode: first period dark
        @(posedge clk);
        #1 en = 1'b0;
        repeat (2) @(negedge clk);
        check("disable_led", 32'(led), 32'h0);
        check("disable_led_al", 32'(led_al), 32'hF);
        check("disable_ptick", 32'(ptick), 32'd0);
        repeat (5) @(negedge clk);
        check("disable_hold_led", 32'(led), 32'h0);
        mode = 2'b01; static_duty = 4'd5;
        @(posedge clk);
        #1 en = 1'b1;
        wait_ptick("restart", 1'b1, 33);
        push4(10, 10, 10, 10);
        measure("restart5", 1'b0, 2'b01, 4'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
